// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_gen
//  Purpose  : Parametrised Fibonacci/Galois LFSR with a valid/ready output
//             stream, seed reload and sequence-period measurement.
//  Revision : 1.0
// ============================================================================
module lfsr_gen #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
    parameter int               GALOIS     = 0,
    parameter logic [WIDTH-1:0] RESET_SEED = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             sel,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] state,
    output logic             wrap,
    output logic [WIDTH-1:0] period
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_step_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_period;
    logic             r_out_valid;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_adv;
    logic             w_hit_start;

    generate
        if (GALOIS != 0) begin : g_galois
            assign w_next = {r_state[WIDTH-2:0], 1'b0} ^ (r_state[WIDTH-1] ? TAPS : '0);
        end else begin : g_fibonacci
            assign w_next = {r_state[WIDTH-2:0], ^(r_state & TAPS)};
        end
    endgenerate

    // An all-zero seed would lock the register up, so it is replaced by 1.
    assign w_load_val  = (seed == '0) ? c_one : seed;
    assign w_adv       = ~r_out_valid | out_ready;
    assign w_hit_start = (w_next == r_start);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RESET_SEED;
            r_start     <= RESET_SEED;
            r_step_cnt  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_period    <= '0;
        end else if (!sel) begin
            r_state     <= w_load_val;
            r_start     <= w_load_val;
            r_step_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else if (w_adv) begin
            r_out_data  <= r_state;
            r_out_valid <= 1'b1;
            r_state     <= w_next;
            r_wrap      <= w_hit_start;
            if (w_hit_start) begin
                r_period   <= r_step_cnt + c_one;
                r_step_cnt <= '0;
            end else begin
                r_step_cnt <= r_step_cnt + c_one;
            end
        end else begin
            // Stalled by the consumer: hold the word, only the pulse clears.
            r_wrap      <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign state     = r_state;
    assign wrap      = r_wrap;
    assign period    = r_period;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_gen
//  Purpose  : Self-checking bench for lfsr_gen (4-bit Fibonacci and Galois).
//  Revision : 1.0
// ============================================================================
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] seed = 4'hF;

    logic       valid_f, wrap_f, valid_g, wrap_g;
    logic [3:0] data_f, state_f, period_f, data_g, state_g, period_g;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .GALOIS(0), .RESET_SEED(4'hF)) u_fib (
        .clk(clk), .rst(rst), .seed(seed), .sel(sel), .out_ready(out_ready),
        .out_valid(valid_f), .out_data(data_f), .state(state_f), .wrap(wrap_f), .period(period_f));

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .GALOIS(1), .RESET_SEED(4'hF)) u_gal (
        .clk(clk), .rst(rst), .seed(seed), .sel(sel), .out_ready(out_ready),
        .out_valid(valid_g), .out_data(data_g), .state(state_g), .wrap(wrap_g), .period(period_g));

    logic [3:0] obs_state[2], obs_data[2], obs_period[2];
    logic       obs_valid[2], obs_wrap[2];
    assign obs_state[0] = state_f;  assign obs_state[1] = state_g;
    assign obs_data[0]  = data_f;   assign obs_data[1]  = data_g;
    assign obs_period[0]= period_f; assign obs_period[1]= period_g;
    assign obs_valid[0] = valid_f;  assign obs_valid[1] = valid_g;
    assign obs_wrap[0]  = wrap_f;   assign obs_wrap[1]  = wrap_g;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: k words emitted since the last load; the
    // k-th word is the (k-1)-th successor of the start value.
    logic [3:0] m_start[2];
    logic [3:0] m_period[2];
    logic       m_wrap[2];
    int         m_k[2];
    int         m_p[2];

    function automatic logic [3:0] ref_next(int d, logic [3:0] s);
        int v = s;
        if (d == 0) return 4'(((v * 2) % 16) + ($countones(s & 4'b1100) % 2));
        return 4'(((v * 2) % 16) ^ ((v >= 8) ? 9 : 0));
    endfunction

    function automatic logic [3:0] ref_state(int d, logic [3:0] s0, int n);
        logic [3:0] s = s0;
        for (int i = 0; i < n; i++) s = ref_next(d, s);
        return s;
    endfunction

    function automatic int ref_period(int d, logic [3:0] s0);
        logic [3:0] s = s0;
        int n = 0;
        do begin
            s = ref_next(d, s);
            n++;
        end while (s != s0 && n < 100);
        return n;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_start[d]  = 4'hF;
            m_k[d]      = 0;
            m_wrap[d]   = 1'b0;
            m_period[d] = 4'h0;
            m_p[d]      = ref_period(d, 4'hF);
        end
    endtask

    // One clock edge, model advanced with the inputs present at the edge.
    task automatic edge_model();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_start[d] = 4'hF; m_k[d] = 0; m_wrap[d] = 1'b0; m_period[d] = 4'h0;
                m_p[d] = ref_period(d, 4'hF);
            end else if (!sel) begin
                m_start[d] = (seed == 4'h0) ? 4'h1 : seed;
                m_k[d]     = 0;
                m_wrap[d]  = 1'b0;
                m_p[d]     = ref_period(d, m_start[d]);
            end else if (m_k[d] == 0 || out_ready) begin
                m_k[d]++;
                m_wrap[d] = (m_k[d] % m_p[d]) == 0;
                if (m_wrap[d]) m_period[d] = 4'(m_p[d]);
            end else begin
                m_wrap[d] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        edge_model();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_state[d] !== 4'hF || obs_valid[d] !== 1'b0 || obs_data[d] !== 4'h0 ||
                obs_wrap[d] !== 1'b0 || obs_period[d] !== 4'h0) begin
                errors++;
                $display("FAIL reset[%0d]: state=%h valid=%b data=%h wrap=%b period=%h, expected F 0 0 0 0",
                         d, obs_state[d], obs_valid[d], obs_data[d], obs_wrap[d], obs_period[d]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_fib_stream();
        logic [3:0] exp_f[15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                                  4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
        int wraps = 0;
        seed = 4'hF; sel = 1'b0; out_ready = 1'b1;
        repeat (3) edge_model();
        sel = 1'b1;
        for (int i = 0; i < 32; i++) begin
            edge_model();
            if (wrap_f) wraps++;
            checks++;
            if (valid_f !== 1'b1 || data_f !== exp_f[i % 15]) begin
                errors++;
                $display("FAIL fib_stream word %0d: valid=%b data=%h, expected 1 %h", i, valid_f, data_f, exp_f[i % 15]);
            end
        end
        checks++;
        if (wraps != 2 || period_f !== 4'd15) begin
            errors++;
            $display("FAIL fib_wrap: wraps=%0d period=%0d, expected 2 15", wraps, period_f);
        end
    endtask

    task automatic test_stall();
        seed = 4'hF; sel = 1'b0; out_ready = 1'b1;
        edge_model();
        sel = 1'b1;
        edge_model();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_model();
            checks++;
            if (valid_f !== 1'b1 || data_f !== 4'hF || state_f !== 4'hE || wrap_f !== 1'b0 || period_f !== m_period[0]) begin
                errors++;
                $display("FAIL stall cycle %0d: valid=%b data=%h state=%h wrap=%b period=%0d, expected 1 F E 0 %0d",
                         i, valid_f, data_f, state_f, wrap_f, period_f, m_period[0]);
            end
        end
        out_ready = 1'b1;
        edge_model();
        checks++;
        if (valid_f !== 1'b1 || data_f !== 4'hE || state_f !== 4'hC) begin
            errors++;
            $display("FAIL stall_resume: valid=%b data=%h state=%h, expected 1 E C", valid_f, data_f, state_f);
        end
    endtask

    task automatic test_galois();
        logic [3:0] exp_g[15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7,
                                  4'hE, 4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC};
        seed = 4'h1; sel = 1'b0; out_ready = 1'b1;
        edge_model();
        sel = 1'b1;
        for (int i = 0; i < 20; i++) begin
            edge_model();
            checks++;
            if (valid_g !== 1'b1 || data_g !== exp_g[i % 15]) begin
                errors++;
                $display("FAIL galois word %0d: valid=%b data=%h, expected 1 %h", i, valid_g, data_g, exp_g[i % 15]);
            end
        end
        checks++;
        if (period_g !== 4'd15) begin
            errors++;
            $display("FAIL galois_period: period=%0d, expected 15", period_g);
        end
    endtask

    task automatic test_zero_seed();
        int zeros = 0;
        seed = 4'h0; sel = 1'b0; out_ready = 1'b1;
        repeat (2) edge_model();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_state[d] !== 4'h1) begin
                errors++;
                $display("FAIL zero_seed_load[%0d]: state=%h, expected 1", d, obs_state[d]);
            end
        end
        sel = 1'b1;
        edge_model();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_valid[d] !== 1'b1 || obs_data[d] !== 4'h1) begin
                errors++;
                $display("FAIL zero_seed_first[%0d]: valid=%b data=%h, expected 1 1", d, obs_valid[d], obs_data[d]);
            end
        end
        for (int i = 0; i < 39; i++) begin
            edge_model();
            if (data_f === 4'h0 || data_g === 4'h0) zeros++;
        end
        checks++;
        if (zeros != 0) begin
            errors++;
            $display("FAIL zero_seed_stream: zero words=%0d, expected 0", zeros);
        end
    endtask

    task automatic test_abort();
        logic [3:0] new_seed;
        seed = 4'($urandom_range(1, 15)); sel = 1'b0; out_ready = 1'b1;
        edge_model();
        sel = 1'b1;
        repeat (7) edge_model();
        new_seed = 4'($urandom_range(0, 15));
        seed = new_seed; sel = 1'b0; out_ready = 1'b0;
        edge_model();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_valid[d] !== 1'b0 || obs_wrap[d] !== 1'b0 || obs_period[d] !== m_period[d] ||
                obs_state[d] !== ((new_seed == 4'h0) ? 4'h1 : new_seed)) begin
                errors++;
                $display("FAIL abort[%0d]: valid=%b wrap=%b state=%h period=%0d, expected 0 0 %h %0d",
                         d, obs_valid[d], obs_wrap[d], obs_state[d], obs_period[d],
                         (new_seed == 4'h0) ? 4'h1 : new_seed, m_period[d]);
            end
        end
    endtask

    task automatic test_random_backpressure();
        for (int r = 0; r < 4; r++) begin
            seed = 4'($urandom_range(0, 15)); sel = 1'b0;
            edge_model();
            sel = 1'b1;
            for (int c = 0; c < 60; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 49) == 0) sel = 1'b0;
                edge_model();
                sel = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (obs_state[d] !== ref_state(d, m_start[d], m_k[d] % m_p[d]) ||
                        obs_valid[d] !== (m_k[d] > 0) || obs_wrap[d] !== m_wrap[d] ||
                        obs_period[d] !== m_period[d] ||
                        (m_k[d] > 0 && obs_data[d] !== ref_state(d, m_start[d], (m_k[d] - 1) % m_p[d]))) begin
                        errors++;
                        $display("FAIL random[%0d] run %0d cyc %0d: state=%h valid=%b data=%h wrap=%b period=%0d, expected state=%h valid=%b data=%h wrap=%b period=%0d",
                                 d, r, c, obs_state[d], obs_valid[d], obs_data[d], obs_wrap[d], obs_period[d],
                                 ref_state(d, m_start[d], m_k[d] % m_p[d]), (m_k[d] > 0),
                                 ref_state(d, m_start[d], (m_k[d] + m_p[d] - 1) % m_p[d]), m_wrap[d], m_period[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        seed = 4'h5; sel = 1'b0; out_ready = 1'b1;
        edge_model();
        sel = 1'b1;
        repeat (4) edge_model();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_valid[d] !== 1'b0 || obs_state[d] !== 4'hF || obs_data[d] !== 4'h0 ||
                obs_wrap[d] !== 1'b0 || obs_period[d] !== 4'h0) begin
                errors++;
                $display("FAIL async_reset[%0d]: valid=%b state=%h data=%h wrap=%b period=%h, expected 0 F 0 0 0",
                         d, obs_valid[d], obs_state[d], obs_data[d], obs_wrap[d], obs_period[d]);
            end
        end
        rst = 1'b1;
        edge_model();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_valid[d] !== 1'b1 || obs_data[d] !== 4'hF || obs_state[d] !== ref_next(d, 4'hF)) begin
                errors++;
                $display("FAIL async_restart[%0d]: valid=%b data=%h state=%h, expected 1 F %h",
                         d, obs_valid[d], obs_data[d], obs_state[d], ref_next(d, 4'hF));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fib_stream();
        test_stall();
        test_galois();
        test_zero_seed();
        test_abort();
        test_random_backpressure();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
